// File: rtl/sram_pkg.sv
// Constants and types shared by the SRAM arbiter, pixel writer and future read clients.
// A request word is {mask, addr, data}, with the mask in the top bits.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned SRAM_DATA_W = 32;
    localparam int unsigned SRAM_MASK_W = 4;
    localparam int unsigned SRAM_REQ_W  = 54;
    localparam int unsigned MASK_LSB    = 50;
    localparam int unsigned ADDR_LSB    = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPack  = 2'd1,
        StDrain = 2'd2
    } writer_state_e;

    function automatic logic [SRAM_REQ_W-1:0] pack_req(
        input logic [SRAM_MASK_W-1:0] mask,
        input logic [SRAM_ADDR_W-1:0] addr,
        input logic [SRAM_DATA_W-1:0] data
    );
        logic [SRAM_REQ_W-1:0] req;
        req                           = '0;
        req[MASK_LSB +: SRAM_MASK_W]  = mask;
        req[ADDR_LSB +: SRAM_ADDR_W]  = addr;
        req[0 +: SRAM_DATA_W]         = data;
        return req;
    endfunction

endpackage

// File: rtl/sram_pixel_writer_if.sv
// Pixel stream in and SRAM write request out for one writer.
// The master modport is the writer's view; slave is the surrounding environment.
interface sram_pixel_writer_if;
    import sram_pkg::*;

    logic                  pix_valid;
    logic                  pix_ready;
    logic [7:0]            pix_data;
    logic                  pix_last;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [SRAM_REQ_W-1:0] wr_req;

    modport master (
        input  pix_valid, pix_data, pix_last, wr_ready,
        output pix_ready, wr_valid, wr_req
    );

    modport slave (
        output pix_valid, pix_data, pix_last, wr_ready,
        input  pix_ready, wr_valid, wr_req
    );

endinterface

// File: rtl/sram_req_reg.sv
// Single-entry ready/valid holding register. The producer may load only while
// o_can_load is high, so a held payload is never overwritten before hand-off.
module sram_req_reg
    import sram_pkg::*;
#(
    parameter int unsigned WIDTH = SRAM_REQ_W
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_can_load,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_can_load = !r_valid | i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;

endmodule

// File: rtl/sram_pixel_writer.sv
// Packs 8-bit pixels four to a 32-bit SRAM word (lane 0 first) and issues
// sequential masked write requests into a frame buffer, with end-of-frame signalling.
module sram_pixel_writer
    import sram_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = SRAM_ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           FRAME_WORDS = 120000
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_frame_start,
    sram_pixel_writer_if.master io_bus,
    output logic                o_frame_done,
    output logic                o_busy,
    output logic [15:0]         o_drop_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(32'(BASE_ADDR) + FRAME_WORDS - 32'd1);

    writer_state_e          r_state, w_state_next;
    logic [1:0]             r_lane, w_lane_next, w_lane_eff;
    logic [ADDR_WIDTH-1:0]  r_addr, w_addr_next, w_addr_eff;
    logic [SRAM_DATA_W-1:0] r_acc, w_word;
    logic [SRAM_MASK_W-1:0] w_mask;
    logic [SRAM_REQ_W-1:0]  w_req;
    logic                   r_start_pend, w_start_pend_next;
    logic                   r_wrap_pend, w_wrap_pend_next;
    logic                   r_frame_done, w_frame_done_next;
    logic [15:0]            r_drop_count, w_drop_count_next;
    logic                   w_start_eff, w_accept, w_pack_px, w_complete;
    logic                   w_can_load, w_xfer;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? BASE_ADDR : a + ADDR_WIDTH'(1);
    endfunction

    assign w_xfer           = io_bus.wr_valid & io_bus.wr_ready;
    assign io_bus.pix_ready = (r_state == StIdle) | ((r_state == StPack) & w_can_load);
    assign w_accept         = io_bus.pix_valid & io_bus.pix_ready;

    // A frame start outside DRAIN takes effect before any pixel in the same cycle.
    assign w_start_eff = i_frame_start & (r_state != StDrain);
    assign w_lane_eff  = w_start_eff ? 2'd0 : r_lane;
    assign w_addr_eff  = w_start_eff ? BASE_ADDR : r_addr;
    assign w_pack_px   = w_accept & (w_start_eff | (r_state == StPack));
    assign w_complete  = w_pack_px & ((w_lane_eff == 2'd3) | io_bus.pix_last);

    always_comb begin
        w_word = '0;
        w_mask = '0;
        for (int i = 0; i < int'(SRAM_MASK_W); i++) begin
            if (i < int'(w_lane_eff)) begin
                w_word[8*i +: 8] = r_acc[8*i +: 8];
                w_mask[i]        = 1'b1;
            end else if (i == int'(w_lane_eff)) begin
                w_word[8*i +: 8] = io_bus.pix_data;
                w_mask[i]        = 1'b1;
            end
        end
    end

    assign w_req = pack_req(w_mask, SRAM_ADDR_W'(w_addr_eff), w_word);

    always_comb begin
        w_state_next      = r_state;
        w_lane_next       = r_lane;
        w_addr_next       = r_addr;
        w_start_pend_next = r_start_pend;
        w_wrap_pend_next  = r_wrap_pend;
        w_frame_done_next = 1'b0;
        w_drop_count_next = r_drop_count;

        if (w_xfer) begin
            w_wrap_pend_next = 1'b0;
        end

        case (r_state)
            StIdle: begin
                if (w_start_eff) begin
                    w_state_next = StPack;
                end else if (w_accept && r_drop_count != 16'hFFFF) begin
                    w_drop_count_next = r_drop_count + 16'd1;
                end
            end
            StPack: begin
            end
            StDrain: begin
                if (i_frame_start) begin
                    w_start_pend_next = 1'b1;
                end
                if (w_can_load) begin
                    w_frame_done_next = 1'b1;
                    w_lane_next       = 2'd0;
                    w_addr_next       = BASE_ADDR;
                    w_start_pend_next = 1'b0;
                    w_state_next      = (r_start_pend | i_frame_start) ? StPack : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase

        if (r_state != StDrain) begin
            w_lane_next = w_lane_eff;
            w_addr_next = w_addr_eff;
            if (w_complete) begin
                w_lane_next = 2'd0;
                w_addr_next = next_addr(w_addr_eff);
                if (io_bus.pix_last) begin
                    w_state_next = StDrain;
                end else if (w_addr_eff == LAST_ADDR) begin
                    w_wrap_pend_next = 1'b1;
                end
            end else if (w_pack_px) begin
                w_lane_next = w_lane_eff + 2'd1;
            end
        end

        // The frame-closing word of a wrapping frame signals done on its hand-off.
        if (r_wrap_pend & w_xfer) begin
            w_frame_done_next = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StIdle;
            r_lane       <= 2'd0;
            r_addr       <= BASE_ADDR;
            r_acc        <= '0;
            r_start_pend <= 1'b0;
            r_wrap_pend  <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop_count <= 16'd0;
        end else begin
            r_state      <= w_state_next;
            r_lane       <= w_lane_next;
            r_addr       <= w_addr_next;
            r_start_pend <= w_start_pend_next;
            r_wrap_pend  <= w_wrap_pend_next;
            r_frame_done <= w_frame_done_next;
            r_drop_count <= w_drop_count_next;
            if (w_pack_px) begin
                r_acc <= w_word;
            end
        end
    end

    sram_req_reg #(
        .WIDTH(SRAM_REQ_W)
    ) u_req_reg (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_load     (w_complete),
        .i_data     (w_req),
        .o_can_load (w_can_load),
        .o_valid    (io_bus.wr_valid),
        .i_ready    (io_bus.wr_ready),
        .o_data     (io_bus.wr_req)
    );

    assign o_frame_done = r_frame_done;
    assign o_busy       = (r_state == StPack) | (r_state == StDrain);
    assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_sram_pixel_writer.sv
// Randomised and directed bench for sram_pixel_writer against a transaction-level
// packing model (pixel queue per word, word index per frame, expected request queue).
module tb_sram_pixel_writer;
    import sram_pkg::*;

    localparam int unsigned FW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_done;
    logic        busy;
    logic [15:0] drop_count;

    sram_pixel_writer_if bus ();

    sram_pixel_writer #(
        .ADDR_WIDTH  (18),
        .BASE_ADDR   (18'h00000),
        .FRAME_WORDS (FW)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_frame_start (frame_start),
        .io_bus        (bus),
        .o_frame_done  (frame_done),
        .o_busy        (busy),
        .o_drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [7:0]  m_cur[$];
    logic [53:0] m_expq[$];
    int          m_widx     = 0;
    bit          m_in_frame = 0;
    int          m_exp_done = 0;
    int          m_drop     = 0;
    int          act_done   = 0;
    int          rdy_mode   = 0;

    task automatic model_start();
        m_cur.delete();
        m_widx     = 0;
        m_in_frame = 1;
    endtask

    task automatic model_pixel(input logic [7:0] d, input bit last);
        logic [31:0] data;
        logic [3:0]  mask;
        if (!m_in_frame) begin
            if (m_drop < 65535) m_drop++;
            return;
        end
        m_cur.push_back(d);
        if (m_cur.size() == 4 || last) begin
            data = '0;
            foreach (m_cur[i]) data = data | (32'(m_cur[i]) << (8 * i));
            mask = 4'((1 << m_cur.size()) - 1);
            m_expq.push_back({mask, 18'(m_widx), data});
            if (last) begin
                m_exp_done++;
                m_in_frame = 0;
            end else if (m_widx == int'(FW) - 1) begin
                m_exp_done++;
            end
            m_widx = (m_widx + 1) % int'(FW);
            m_cur.delete();
        end
    endtask

    // Monitor: hand-offs against the model, stability while stalled, frame_done pulses.
    bit          hold = 0;
    logic [53:0] hold_req;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 0;
        end else begin
            if (hold) begin
                check_eq("hold_valid", 64'(bus.wr_valid), 64'd1);
                check_eq("hold_req", 64'(bus.wr_req), 64'(hold_req));
            end
            if (bus.wr_valid && bus.wr_ready) begin
                if (m_expq.size() == 0) check_eq("unexpected_req", 64'(bus.wr_valid), 64'd0);
                else check_eq("wr_req", 64'(bus.wr_req), 64'(m_expq.pop_front()));
            end
            hold     = bus.wr_valid && !bus.wr_ready;
            hold_req = bus.wr_req;
            if (frame_done) act_done++;
        end
    end

    // Called #1 after a posedge; returns there one cycle later.
    task automatic drive_cycle(input bit st, input bit v, input logic [7:0] d, input bit l,
                               output bit acc);
        frame_start   = st;
        bus.pix_valid = v;
        bus.pix_data  = d;
        bus.pix_last  = l;
        case (rdy_mode)
            0:       bus.wr_ready = 1'b1;
            1:       bus.wr_ready = 1'b0;
            default: bus.wr_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        if (st) model_start();
        acc = v && bus.pix_ready;
        if (acc) model_pixel(d, l);
        @(posedge clk);
        #1;
        frame_start   = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
    endtask

    task automatic send_pixel(input logic [7:0] d, input bit l);
        bit acc;
        int tries = 0;
        do begin
            drive_cycle(0, 1, d, l, acc);
            tries++;
        end while (!acc && tries < 200);
        if (!acc) check_eq("pix_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 8'h00, 0, acc);
    endtask

    task automatic start_frame();
        bit acc;
        drive_cycle(1, 0, 8'h00, 0, acc);
    endtask

    task automatic settle(input string tag);
        int k = 0;
        rdy_mode = 0;
        while (m_expq.size() != 0 && k < 100) begin
            idle_cycles(1);
            k++;
        end
        idle_cycles(4);
        check_eq({tag, "_queue_empty"}, 64'(m_expq.size()), 64'd0);
        check_eq({tag, "_frame_done"}, 64'(act_done), 64'(m_exp_done));
        check_eq({tag, "_drop_count"}, 64'(drop_count), 64'(m_drop));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n_acc;
        logic [7:0] px;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'h00;
        bus.pix_last  = 1'b0;
        bus.wr_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
        check_eq("rst_wr_req", 64'(bus.wr_req), 64'd0);
        check_eq("rst_frame_done", 64'(frame_done), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_drop_count", 64'(drop_count), 64'd0);
        check_eq("rst_pix_ready", 64'(bus.pix_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two full words
        rdy_mode = 0;
        start_frame();
        check_eq("busy_after_start", 64'(busy), 64'd1);
        for (int i = 1; i <= 8; i++) send_pixel(8'(i), 0);
        settle("full_words");

        // Partial final word
        start_frame();
        for (int i = 0; i < 6; i++) send_pixel(8'(8'hA0 + i), i == 5);
        settle("partial_last");
        check_eq("idle_after_drain", 64'(busy), 64'd0);

        // Backpressure
        start_frame();
        rdy_mode = 1;
        px = 8'h10;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(0, 1, px, 0, acc);
            if (acc) begin
                px++;
                n_acc++;
            end
        end
        check_eq("stall_pix_ready", 64'(bus.pix_ready), 64'd0);
        check_eq("stall_accepts", 64'(n_acc), 64'd4);
        rdy_mode = 0;
        for (int i = n_acc; i < 12; i++) begin
            send_pixel(px, i == 11);
            px++;
        end
        settle("backpressure");

        // Address wrap
        start_frame();
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) send_pixel(8'($urandom), 0);
        settle("wrap");
        send_pixel(8'h55, 1);
        settle("wrap_close");

        // Restart mid-word, with a pixel in the restart cycle
        start_frame();
        send_pixel(8'h61, 0);
        send_pixel(8'h62, 0);
        drive_cycle(1, 1, 8'h77, 0, acc);
        for (int i = 0; i < 3; i++) send_pixel(8'(8'h78 + i), 0);
        send_pixel(8'h90, 1);
        settle("restart");

        // Pixels while idle
        for (int i = 0; i < 5; i++) send_pixel(8'(8'hC0 + i), 0);
        check_eq("drop5", 64'(drop_count), 64'd5);
        check_eq("drop_no_valid", 64'(bus.wr_valid), 64'd0);
        settle("drops");

        // Frame start during drain
        start_frame();
        for (int i = 0; i < 3; i++) send_pixel(8'(8'hD0 + i), 0);
        rdy_mode = 1;
        send_pixel(8'hD3, 1);
        start_frame();
        check_eq("drain_busy", 64'(busy), 64'd1);
        rdy_mode = 0;
        idle_cycles(3);
        for (int i = 0; i < 4; i++) send_pixel(8'(8'hE0 + i), i == 3);
        settle("start_in_drain");

        // Random traffic
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                        8'($urandom), $urandom_range(0, 15) == 0, acc);
        end
        start_frame();
        send_pixel(8'hEE, 1);
        settle("random");

        // Reset with a request pending
        start_frame();
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) send_pixel(8'(8'h30 + i), 0);
        idle_cycles(1);
        check_eq("pre_reset_valid", 64'(bus.wr_valid), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_valid", 64'(bus.wr_valid), 64'd0);
        check_eq("async_reset_busy", 64'(busy), 64'd0);
        m_expq.delete();
        m_cur.delete();
        m_in_frame = 0;
        m_widx     = 0;
        m_drop     = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_reset_drop", 64'(drop_count), 64'd0);
        rdy_mode = 0;
        start_frame();
        for (int i = 0; i < 5; i++) send_pixel(8'(8'h40 + i), i == 4);
        settle("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_pixel_writer.md
Name: sram_pixel_writer

Overview:
- Upstream producer for one write port (W0 or W1) of the SRAM arbiter.
- Accepts a stream of 8-bit grayscale pixels and packs 4 pixels into each 32-bit SRAM word, lane 0 first.
- Generates sequential word addresses from a frame base and emits 54-bit {mask,addr,data} write requests with ready/valid handshakes.
- Handles frame start, partial final words (byte mask) and end-of-frame signalling for the feature-detection frame buffer.

Parameters:
- ADDR_WIDTH, 18, SRAM word address width; fixed by the arbiter request format.
- BASE_ADDR, 18'h00000, first word address of the frame buffer.
- FRAME_WORDS, 120000, words per frame (800x600 pixels / 4); address wrap limit.

Ports:
- clock  in  1  single clock (the producer-side write clock of the arbiter port)
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse; begins a new frame at BASE_ADDR
- pix_valid  in  1  pixel present
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready
- pix_data  in  8  pixel value
- pix_last  in  1  qualifies the final pixel of the frame
- wr_valid  out  1  request valid (drives arbiter w*_din_valid)
- wr_ready  in  1  arbiter w*_din_ready
- wr_req  out  54  {mask[3:0], addr[17:0], data[31:0]}
- frame_done  out  1  one-cycle pulse after the last word of a frame is handed off
- busy  out  1  high in PACK or DRAIN
- drop_count  out  16  saturating count of pixels discarded while IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; wr_valid=0; wr_req=0; frame_done=0; busy=0; drop_count=0; lane=0; word address = BASE_ADDR.
- Lane mapping:
  - pixel n of a word occupies data[8n+7:8n];
  - mask bit n=1 enables byte n;
  - a full word carries mask 4'b1111.
- Output holding register: a single entry.
  - wr_valid is registered.
  - A transfer occurs on wr_valid & wr_ready.
  - wr_req is held stable while wr_valid & !wr_ready.
- pix_ready = (state==IDLE) | (state==PACK & (!wr_valid | wr_ready)); combinational from registered state plus wr_ready.
- States:
  - IDLE:
    - frame_start -> PACK; lane=0; addr=BASE_ADDR.
    - Pixels accepted in IDLE are discarded; drop_count increments and saturates at 16'hFFFF.
  - PACK:
    - Each accepted pixel is written into accumulator lane `lane`; lane increments.
    - On lane==3, or pix_last: the accumulator moves into the output register the same cycle; mask = bits 0..lane set; addr = current word address; wr_valid=1 next cycle; lane=0; address increments.
    - Latency: accept of the completing pixel to wr_valid high = 1 cycle.
    - If pix_last -> DRAIN.
  - DRAIN:
    - pix_ready=0.
    - Once the output register is empty (or transferring this cycle), pulse frame_done for 1 cycle -> IDLE; addr=BASE_ADDR.
- Address wrap: after emitting word address BASE_ADDR+FRAME_WORDS-1 without pix_last, the next word uses BASE_ADDR, and frame_done pulses once when that word is handed off. Address arithmetic is ADDR_WIDTH bits with no carry-out.
- frame_start in PACK: the partial accumulator is discarded (not written), lane=0, addr=BASE_ADDR. A request already in the output register is still delivered unchanged.
- frame_start in DRAIN: taken after the drain completes (frame_done pulses first), then -> PACK. It is held pending via a 1-bit flag.
- Simultaneous frame_start and accepted pixel in IDLE or PACK: frame_start is applied first, and the pixel becomes lane 0 of the new frame; it is not counted as dropped.
- pix_last on the first pixel of a word: emits mask 4'b0001 with unused lanes zero.
- reset_n asserted mid-frame: all state is cleared immediately; any pending request is lost and wr_valid falls asynchronously.

Decomposition:
- Shared package (sram_pkg): SRAM_ADDR_W=18, SRAM_DATA_W=32, SRAM_MASK_W=4, SRAM_REQ_W=54, the request field offsets (MASK_LSB=50, ADDR_LSB=32), and the writer state encoding (IDLE/PACK/DRAIN). The arbiter and future read clients use the same constants.
- One natural sub-module: sram_req_reg, the single-entry ready/valid holding register (54-bit payload). It is reused by a future read-address generator.

Test Plan:
- Reset and release, frame_start, then 8 pixels 0x01..0x08 with wr_ready=1 -> two requests: {4'hF,18'h00000,32'h04030201} and {4'hF,18'h00001,32'h08070605}.
- 6 pixels 0xA0..0xA5, last on 0xA5 -> second request {4'h3,18'h00001,32'h0000A5A4}, then frame_done pulses once, then IDLE.
- wr_ready=0 for 10 cycles while pixels stream -> pix_ready drops after the first full word, wr_req remains stable throughout, and no pixel is lost after wr_ready returns (data checked against a scoreboard).
- FRAME_WORDS=4 override, 20 pixels without pix_last -> addresses run 0,1,2,3,0; frame_done pulses on hand-off of word address 3.
- frame_start after 2 pixels of a word -> that partial word is never emitted; the next request has addr 18'h00000 and contains the new pixels.
- 5 pixels sent in IDLE before frame_start -> drop_count=5 and no wr_valid; assert reset_n low while wr_valid=1 -> wr_valid=0 immediately.
